// File: rtl/sprite_pkg.sv
// Shared types and sizing helpers for the parametrised sprite renderer.
package sprite_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOAD,
    S_SETUP,
    S_FETCH,
    S_WAIT_HSTART,
    S_DRAW
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  function automatic int words_of(input int w, input int bpp, input int dw);
    return w * bpp / dw;
  endfunction

  localparam int SPR_W      = 16;
  localparam int SPR_H      = 16;
  localparam int SPR_BPP    = 1;
  localparam int SPR_ROM_DW = 8;
  localparam int SPR_WORDS  = words_of(SPR_W, SPR_BPP, SPR_ROM_DW);
  localparam int SPR_AW     = clog2(SPR_H * SPR_WORDS);

endpackage

// File: rtl/sprite_row_buffer.sv
// One sprite row: word-wide write port, mirrored pixel read port.
module sprite_row_buffer
  import sprite_pkg::*;
#(
  parameter int W      = SPR_W,
  parameter int BPP    = SPR_BPP,
  parameter int ROM_DW = SPR_ROM_DW,
  parameter int WW     = 1,
  parameter int XW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [WW-1:0]     wword,
  input  logic [ROM_DW-1:0] wdata,
  input  logic [XW-1:0]     rx,
  input  logic              rmirror,
  output logic [BPP-1:0]    rpix
);

  localparam int WORDS = words_of(W, BPP, ROM_DW);

  logic [W*BPP-1:0] bits;
  logic [XW-1:0]    idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bits <= '0;
    end else if (we) begin
      for (int i = 0; i < WORDS; i++) begin
        if (wword == WW'(i)) bits[i*ROM_DW +: ROM_DW] <= wdata;
      end
    end
  end

  assign idx = rmirror ? XW'(W - 1) - rx : rx;

  always_comb begin
    rpix = '0;
    for (int i = 0; i < W; i++) begin
      if (idx == XW'(i)) rpix = bits[i*BPP +: BPP];
    end
  end

endmodule

// File: rtl/sprite_renderer_n.sv
// Per-scanline sprite row fetch from an external ROM and scaled pixel
// streaming, with mirroring and a late-hstart miss pulse.
module sprite_renderer_n
  import sprite_pkg::*;
#(
  parameter int W      = SPR_W,
  parameter int H      = SPR_H,
  parameter int BPP    = SPR_BPP,
  parameter int ROM_DW = SPR_ROM_DW,
  parameter int XSCALE = 1,
  parameter int YSCALE = 1,
  localparam int WORDS = words_of(W, BPP, ROM_DW),
  localparam int AW    = clog2(H * WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vstart,
  input  logic              load,
  input  logic              hstart,
  input  logic              hmirror,
  input  logic              vmirror,
  output logic [AW-1:0]     rom_addr,
  input  logic [ROM_DW-1:0] rom_bits,
  output logic [BPP-1:0]    pix,
  output logic              gfx,
  output logic              busy,
  output logic              miss
);

  localparam int RW = clog2(H) + 1;
  localparam int WW = clog2(WORDS) + 1;
  localparam int XW = clog2(W);

  state_t        state;
  logic [RW-1:0] row;
  logic [2:0]    yrep;
  logic [WW-1:0] word;
  logic [XW-1:0] x;
  logic [1:0]    xrep;

  logic [RW-1:0] srow;
  logic [RW-1:0] row_nx;
  logic [2:0]    yrep_nx;
  logic          yrep_wrap;
  logic          last_row;
  logic          draw_last;
  logic          late;
  logic          end_line;
  logic          fetch_we;
  logic [BPP-1:0] rpix;

  assign srow      = vmirror ? RW'(H - 1) - row : row;
  assign yrep_nx   = yrep + 3'd1;
  assign yrep_wrap = yrep_nx == 3'(YSCALE);
  assign row_nx    = row + RW'(1);
  assign last_row  = yrep_wrap && (row_nx == RW'(H));

  assign draw_last = (state == S_DRAW)
                  && (xrep == 2'(XSCALE - 1))
                  && (x == XW'(W - 1));
  assign late      = hstart
                  && ((state == S_SETUP) || (state == S_FETCH));
  assign end_line  = draw_last || late;
  assign fetch_we  = (state == S_FETCH) && !hstart;
  assign busy      = state != S_IDLE;

  sprite_row_buffer #(
    .W      (W),
    .BPP    (BPP),
    .ROM_DW (ROM_DW),
    .WW     (WW),
    .XW     (XW)
  ) u_rowbuf (
    .clk     (clk),
    .reset   (reset),
    .we      (fetch_we),
    .wword   (word),
    .wdata   (rom_bits),
    .rx      (x),
    .rmirror (hmirror),
    .rpix    (rpix)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      row      <= '0;
      yrep     <= '0;
      word     <= '0;
      x        <= '0;
      xrep     <= '0;
      rom_addr <= '0;
      pix      <= '0;
      gfx      <= 1'b0;
      miss     <= 1'b0;
    end else begin
      miss <= 1'b0;
      pix  <= '0;
      gfx  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          row  <= '0;
          yrep <= '0;
          if (vstart) state <= S_WAIT_LOAD;
        end
        S_WAIT_LOAD: begin
          word <= '0;
          x    <= '0;
          xrep <= '0;
          if (load) state <= S_SETUP;
        end
        S_SETUP: begin
          if (hstart) begin
            miss <= 1'b1;
          end else begin
            rom_addr <= AW'(srow) * AW'(WORDS) + AW'(word);
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (hstart) begin
            miss <= 1'b1;
          end else if (word == WW'(WORDS - 1)) begin
            state <= S_WAIT_HSTART;
          end else begin
            word  <= word + WW'(1);
            state <= S_SETUP;
          end
        end
        S_WAIT_HSTART: begin
          if (hstart) state <= S_DRAW;
        end
        S_DRAW: begin
          pix <= rpix;
          gfx <= |rpix;
          if (xrep == 2'(XSCALE - 1)) begin
            xrep <= '0;
            x    <= x + XW'(1);
          end else begin
            xrep <= xrep + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Line end from either a finished draw or a late hstart.
      if (end_line) begin
        if (yrep_wrap) begin
          yrep <= '0;
          row  <= row_nx;
        end else begin
          yrep <= yrep_nx;
        end
        state <= last_row ? S_IDLE : S_WAIT_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_sprite_renderer_n.sv
// Self-checking bench: default renderer plus a 2-bpp, 2x-scaled 8x8 one
// driven in lockstep, checked against a row/pixel arithmetic model.
module tb_sprite_renderer_n;
  import sprite_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic vstart = 1'b0;
  logic load = 1'b0;
  logic hstart = 1'b0;
  logic hmirror = 1'b0;
  logic vmirror = 1'b0;

  logic [4:0] addr0;
  logic [7:0] bits0;
  logic [0:0] pix0;
  logic       gfx0, busy0, miss0;
  logic [3:0] addr1;
  logic [7:0] bits1;
  logic [1:0] pix1;
  logic       gfx1, busy1, miss1;

  logic [7:0] rom0 [32];
  logic [7:0] rom1 [16];

  assign bits0 = rom0[addr0];
  assign bits1 = rom1[addr1];

  always #5 clk = ~clk;

  sprite_renderer_n dut0 (
    .clk(clk), .reset(reset), .vstart(vstart), .load(load),
    .hstart(hstart), .hmirror(hmirror), .vmirror(vmirror),
    .rom_addr(addr0), .rom_bits(bits0), .pix(pix0), .gfx(gfx0),
    .busy(busy0), .miss(miss0)
  );

  sprite_renderer_n #(
    .W(8), .H(8), .BPP(2), .ROM_DW(8), .XSCALE(2), .YSCALE(2)
  ) dut1 (
    .clk(clk), .reset(reset), .vstart(vstart), .load(load),
    .hstart(hstart), .hmirror(hmirror), .vmirror(vmirror),
    .rom_addr(addr1), .rom_bits(bits1), .pix(pix1), .gfx(gfx1),
    .busy(busy1), .miss(miss1)
  );

  typedef struct {
    bit vm;
    bit hm;
    bit rnd;
    int miss_line;
    int dly;
    bit noise;
    int ea0;
    int ea1;
    int eb0;
    int eb1;
  } scen_t;

  scen_t scen [5];
  int e4_pix [4];
  int e4_gfx [4];
  int n_vec;
  int n_mis;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 16x16 1-bpp, one row per line.
  function automatic int exp_pix0(input int line, input int k);
    int sr;
    int xi;
    logic [15:0] rb;
    sr = vmirror ? 15 - line : line;
    rb = {rom0[sr*2+1], rom0[sr*2]};
    xi = hmirror ? 15 - k : k;
    return int'(rb[xi]);
  endfunction

  // 8x8 2-bpp, each row shown twice, each pixel held two clocks.
  function automatic int exp_pix1(input int line, input int k);
    int sr;
    int xi;
    logic [15:0] rb;
    sr = vmirror ? 7 - line / 2 : line / 2;
    rb = {rom1[sr*2+1], rom1[sr*2]};
    xi = hmirror ? 7 - k / 2 : k / 2;
    return int'(rb[xi*2 +: 2]);
  endfunction

  task automatic do_line(input int line, input int dly, input bit noise,
                         input bit chk_addr, input scen_t s,
                         input bit chk_e4);
    int e0;
    int e1;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    if (chk_addr) begin
      chk("addr0_w0", addr0, s.ea0);
      chk("addr1_w0", addr1, s.eb0);
    end
    step();
    step();
    if (chk_addr) begin
      chk("addr0_w1", addr0, s.ea1);
      chk("addr1_w1", addr1, s.eb1);
    end
    step();
    chk("busy_wait", busy0, 1);
    repeat (dly) begin
      if (noise) load = 1'($urandom_range(0, 1));
      chk("gfx_idle", gfx0, 0);
      step();
    end
    load = 1'b0;
    hstart = 1'b1;
    step();
    hstart = 1'b0;
    chk("gfx_pre", gfx0, 0);
    step();
    for (int k = 0; k < 16; k++) begin
      e0 = exp_pix0(line, k);
      e1 = exp_pix1(line, k);
      chk("pix0", pix0, e0);
      chk("gfx0", gfx0, e0 != 0);
      chk("pix1", pix1, e1);
      chk("gfx1", gfx1, e1 != 0);
      if (chk_e4 && k < 8 && k % 2 == 0) begin
        chk("e4_pix", pix1, e4_pix[k/2]);
        chk("e4_gfx", gfx1, e4_gfx[k/2]);
      end
      step();
    end
    chk("gfx0_after", gfx0, 0);
    chk("gfx1_after", gfx1, 0);
  endtask

  task automatic do_miss();
    load = 1'b1;
    step();
    load = 1'b0;
    hstart = 1'b1;
    step();
    hstart = 1'b0;
    chk("miss0_on", miss0, 1);
    chk("miss1_on", miss1, 1);
    step();
    chk("miss0_off", miss0, 0);
    chk("miss1_off", miss1, 0);
    repeat (4) begin
      chk("gfx0_miss", gfx0, 0);
      chk("gfx1_miss", gfx1, 0);
      step();
    end
  endtask

  task automatic fill_rom(input bit rnd);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r = 16'h8001 ^ 16'(i);
      rom0[2*i]   = rnd ? 8'($urandom) : r[7:0];
      rom0[2*i+1] = rnd ? 8'($urandom) : r[15:8];
      rom1[i]     = rnd ? 8'($urandom) : 8'(i * 29 + 3);
    end
    if (!rnd) rom1[0] = 8'hE4;
  endtask

  task automatic run_sprite(input int si);
    scen_t s;
    int dly;
    s = scen[si];
    vmirror = s.vm;
    hmirror = s.hm;
    fill_rom(s.rnd);
    vstart = 1'b1;
    step();
    vstart = 1'b0;
    chk("busy_start", busy0, 1);
    for (int l = 0; l < 16; l++) begin
      if (l == s.miss_line) begin
        do_miss();
      end else begin
        dly = (s.dly < 0) ? int'($urandom_range(0, 6)) : s.dly;
        do_line(l, dly, s.noise, l == 0, s, si == 0 && l == 0);
      end
      step();
    end
    chk("busy0_done", busy0, 0);
    chk("busy1_done", busy1, 0);
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    scen[0] = '{0, 0, 0, -1, 40, 0, 0, 1, 0, 1};
    scen[1] = '{1, 1, 0, -1, 3, 0, 30, 31, 14, 15};
    scen[2] = '{0, 1, 1, 3, -1, 1, 0, 1, 0, 1};
    scen[3] = '{1, 0, 1, 0, -1, 0, 30, 31, 14, 15};
    scen[4] = '{0, 0, 1, 15, -1, 1, 0, 1, 0, 1};
    e4_pix = '{0, 1, 2, 3};
    e4_gfx = '{0, 1, 1, 1};
    fill_rom(1'b0);

    step();
    step();
    chk("rst_busy", busy0, 0);
    chk("rst_pix", pix0, 0);
    chk("rst_gfx", gfx0, 0);
    chk("rst_miss", miss0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_busy1", busy1, 0);
    reset = 1'b1;
    step();

    for (int si = 0; si < 5; si++) run_sprite(si);

    // Reset asserted for one clock in the middle of a drawn line.
    vmirror = 1'b0;
    hmirror = 1'b0;
    fill_rom(1'b0);
    vstart = 1'b1;
    step();
    vstart = 1'b0;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (4) step();
    hstart = 1'b1;
    step();
    hstart = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_busy0", busy0, 0);
    chk("mid_rst_pix0", pix0, 0);
    chk("mid_rst_gfx0", gfx0, 0);
    chk("mid_rst_busy1", busy1, 0);
    chk("mid_rst_gfx1", gfx1, 0);
    step();
    chk("post_rst_busy", busy0, 0);
    vstart = 1'b1;
    step();
    vstart = 1'b0;
    do_line(0, 2, 1'b0, 1'b1, scen[0], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
